// File: rtl/mips_pipe_hazard_ctrl_if.sv
// ID-stage hazard interface: decode-side request fields plus stall/flush/forward controls.
interface mips_pipe_hazard_ctrl_if #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic          id_valid_i;
    logic [RW-1:0] id_rs_i;
    logic [RW-1:0] id_rt_i;
    logic          id_use_rs_i;
    logic          id_use_rt_i;
    logic [RW-1:0] id_rd_i;
    logic          id_wr_i;
    logic          id_load_i;
    logic          ex_hold_i;
    logic          redirect_i;

    logic             stall_o;
    logic             bubble_o;
    logic             flush_id_o;
    logic [FW-1:0]    fwd_a_o;
    logic [FW-1:0]    fwd_b_o;
    logic [DEPTH-1:0] stage_valid_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_rd_i, id_wr_i, id_load_i, ex_hold_i, redirect_i,
        input  stall_o, bubble_o, flush_id_o, fwd_a_o, fwd_b_o, stage_valid_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_rd_i, id_wr_i, id_load_i, ex_hold_i, redirect_i,
        output stall_o, bubble_o, flush_id_o, fwd_a_o, fwd_b_o, stage_valid_o
    );
endinterface

// File: rtl/mips_pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the MIPS32 in-order pipeline with DEPTH tracked stages after ID.
// Stage k (1=EX .. DEPTH=WB) is held in stage_q[k-1].
module mips_pipe_hazard_ctrl #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NREG       = 32,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned WB_BYPASS  = 1
) (
    input logic                         clk,
    input logic                         reset,
    mips_pipe_hazard_ctrl_if.slave      hz
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dest;
        logic          wr;
        logic          load;
    } entry_t;

    entry_t stage_q [DEPTH];
    entry_t stage_d [DEPTH];

    logic [FW-1:0]    fwd_a_c;
    logic [FW-1:0]    fwd_b_c;
    logic             hazard_c;
    logic             stall_c;
    logic             bubble_c;
    logic             flush_c;
    logic [DEPTH-1:0] valid_c;
    entry_t           id_entry_c;

    // A stage can supply register r; the WB stage only when it is a bypass source.
    function automatic logic match(input entry_t e, input int unsigned k, input logic [RW-1:0] r);
        return e.valid && e.wr && (e.dest == r) && (r != '0) &&
               ((k < DEPTH) || (WB_BYPASS != 0));
    endfunction

    // Forward selects (youngest matching stage wins) and load-use / hold detection.
    always_comb begin
        fwd_a_c  = '0;
        fwd_b_c  = '0;
        hazard_c = 1'b0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (hz.id_valid_i && hz.id_use_rs_i && match(stage_q[k-1], k, hz.id_rs_i))
                fwd_a_c = FW'(k);
            if (hz.id_valid_i && hz.id_use_rt_i && match(stage_q[k-1], k, hz.id_rt_i))
                fwd_b_c = FW'(k);
        end
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (hz.id_valid_i &&
                ((stage_q[k-1].load && (k < LOAD_READY)) || ((k == 1) && hz.ex_hold_i)) &&
                ((hz.id_use_rs_i && match(stage_q[k-1], k, hz.id_rs_i)) ||
                 (hz.id_use_rt_i && match(stage_q[k-1], k, hz.id_rt_i))))
                hazard_c = 1'b1;
        end
    end

    // Control priority: hold > redirect > load-use > normal advance.
    always_comb begin
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        flush_c    = 1'b0;
        stage_d    = stage_q;
        id_entry_c = '0;
        if (hz.id_valid_i) begin
            id_entry_c.valid = 1'b1;
            id_entry_c.dest  = hz.id_rd_i;
            id_entry_c.wr    = hz.id_wr_i;
            id_entry_c.load  = hz.id_load_i;
        end
        if (hz.ex_hold_i) begin
            stall_c    = 1'b1;
            stage_d[1] = '0;
            for (int unsigned i = 2; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end else if (hz.redirect_i || hazard_c) begin
            flush_c    = hz.redirect_i;
            stall_c    = !hz.redirect_i;
            bubble_c   = 1'b1;
            stage_d[0] = '0;
            for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end else begin
            stage_d[0] = id_entry_c;
            for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_comb begin
        valid_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) valid_c[i] = stage_q[i].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
    end

    // Outputs forced low while reset is asserted, independent of the ID inputs.
    assign hz.stall_o       = stall_c  & ~reset;
    assign hz.bubble_o      = bubble_c & ~reset;
    assign hz.flush_id_o    = flush_c  & ~reset;
    assign hz.fwd_a_o       = reset ? '0 : fwd_a_c;
    assign hz.fwd_b_o       = reset ? '0 : fwd_b_c;
    assign hz.stage_valid_o = reset ? '0 : valid_c;
endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// Directed bench: DEPTH=3/LOAD_READY=2 instance for most scenarios, DEPTH=5/LOAD_READY=3 for load latency.
module tb_mips_pipe_hazard_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    mips_pipe_hazard_ctrl_if #(.NREG(32), .DEPTH(3)) ifa ();
    mips_pipe_hazard_ctrl_if #(.NREG(32), .DEPTH(5)) ifb ();

    mips_pipe_hazard_ctrl #(.DEPTH(3), .NREG(32), .LOAD_READY(2), .WB_BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .hz(ifa.slave));
    mips_pipe_hazard_ctrl #(.DEPTH(5), .NREG(32), .LOAD_READY(3), .WB_BYPASS(1)) u_b (
        .clk(clk), .reset(reset), .hz(ifb.slave));

    always #5 clk = ~clk;

    task automatic drive_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic [4:0] rd,
                           input logic wr, input logic ld);
        ifa.id_valid_i = v;   ifa.id_rs_i = rs;     ifa.id_rt_i = rt;
        ifa.id_use_rs_i = urs; ifa.id_use_rt_i = urt; ifa.id_rd_i = rd;
        ifa.id_wr_i = wr;     ifa.id_load_i = ld;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic [4:0] rd,
                           input logic wr, input logic ld);
        ifb.id_valid_i = v;   ifb.id_rs_i = rs;     ifb.id_rt_i = rt;
        ifb.id_use_rs_i = urs; ifb.id_use_rt_i = urt; ifb.id_rd_i = rd;
        ifb.id_wr_i = wr;     ifb.id_load_i = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0, 0);
        ifa.ex_hold_i = 0; ifa.redirect_i = 0;
        ifb.ex_hold_i = 0; ifb.redirect_i = 0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        logic [2:0] ctl;
        reset = 1;
        drive_a(1, 3, 3, 1, 1, 3, 1, 1);
        ifa.ex_hold_i = 1; ifa.redirect_i = 1;
        drive_b(0, 0, 0, 0, 0, 0, 0, 0);
        ifb.ex_hold_i = 0; ifb.redirect_i = 0;
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", ctl); end
        n_chk++; if ({ifa.fwd_a_o, ifa.fwd_b_o, ifa.stage_valid_o} !== 7'd0) begin n_fail++;
            $display("FAIL reset_fwd_sv: got %b want 0", {ifa.fwd_a_o, ifa.fwd_b_o, ifa.stage_valid_o}); end
        n_chk++; if (ifb.stage_valid_o !== 5'b0) begin n_fail++; $display("FAIL reset_sv_b: got %b want 0", ifb.stage_valid_o); end
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        ifa.ex_hold_i = 0; ifa.redirect_i = 0;
        @(negedge clk);
        reset = 0;
        step();
    endtask

    task automatic test_load_use();
        logic [2:0] ctl;
        drive_a(1, 1, 0, 1, 0, 3, 1, 1);                 // lw r3
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL lu_first: got %b want 000", ctl); end
        step();
        drive_a(1, 3, 5, 1, 1, 4, 1, 0);                 // add r4,r3,r5
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b110) begin n_fail++; $display("FAIL lu_stall: got %b want 110", ctl); end
        step();
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL lu_release: got %b want 000", ctl); end
        n_chk++; if ({ifa.fwd_a_o, ifa.fwd_b_o} !== {2'd2, 2'd0}) begin n_fail++;
            $display("FAIL lu_fwd: got a=%0d b=%0d want a=2 b=0", ifa.fwd_a_o, ifa.fwd_b_o); end
        n_chk++; if (ifa.stage_valid_o !== 3'b010) begin n_fail++; $display("FAIL lu_sv: got %b want 010", ifa.stage_valid_o); end
        drain();
    endtask

    task automatic test_forward();
        drive_a(1, 1, 2, 1, 1, 3, 1, 0); step();         // add r3
        drive_a(1, 1, 2, 1, 1, 3, 1, 0); step();         // add r3 again
        drive_a(1, 3, 3, 1, 1, 6, 1, 0);                 // sub r6,r3,r3
        settle();
        n_chk++; if ({ifa.stall_o, ifa.bubble_o, ifa.fwd_a_o, ifa.fwd_b_o} !== {1'b0, 1'b0, 2'd1, 2'd1}) begin n_fail++;
            $display("FAIL fwd_both: got stall=%b a=%0d b=%0d want stall=0 a=1 b=1", ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o); end
        n_chk++; if (ifa.stage_valid_o !== 3'b011) begin n_fail++; $display("FAIL fwd_sv: got %b want 011", ifa.stage_valid_o); end
        step();
        drive_a(1, 3, 0, 1, 1, 7, 1, 0);                 // add r7,r3,r0
        settle();
        n_chk++; if ({ifa.fwd_a_o, ifa.fwd_b_o} !== {2'd2, 2'd0}) begin n_fail++;
            $display("FAIL fwd_stage2: got a=%0d b=%0d want a=2 b=0", ifa.fwd_a_o, ifa.fwd_b_o); end
        drain();
    endtask

    task automatic test_wb_bypass();
        drive_a(1, 1, 2, 1, 1, 7, 1, 0); step();         // add r7
        drive_a(0, 0, 0, 0, 0, 0, 0, 0); step();
        step();
        drive_a(1, 7, 7, 1, 0, 9, 1, 0);                 // rs=r7 used, rt unused
        settle();
        n_chk++; if ({ifa.fwd_a_o, ifa.fwd_b_o} !== {2'd3, 2'd0}) begin n_fail++;
            $display("FAIL wb_fwd: got a=%0d b=%0d want a=3 b=0", ifa.fwd_a_o, ifa.fwd_b_o); end
        step();
        drive_a(1, 7, 0, 1, 0, 10, 1, 0);
        settle();
        n_chk++; if (ifa.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL wb_retired: got a=%0d want 0", ifa.fwd_a_o); end
        drain();
    endtask

    task automatic test_ex_hold();
        logic [2:0] exp_sv [4];
        logic [2:0] ctl;
        exp_sv[0] = 3'b011; exp_sv[1] = 3'b101; exp_sv[2] = 3'b001; exp_sv[3] = 3'b001;
        drive_a(1, 1, 2, 1, 1, 10, 1, 0); step();        // or r10
        drive_a(1, 1, 2, 1, 1, 8, 1, 0);  step();        // mult r8
        drive_a(1, 8, 10, 1, 1, 9, 1, 0);                // add r9,r8,r10
        ifa.ex_hold_i = 1;
        for (int i = 0; i < 4; i++) begin
            ifa.redirect_i = (i == 1);
            settle();
            ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
            n_chk++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL hold_ctl[%0d]: got %b want 100", i, ctl); end
            n_chk++; if (ifa.stage_valid_o !== exp_sv[i]) begin n_fail++;
                $display("FAIL hold_sv[%0d]: got %b want %b", i, ifa.stage_valid_o, exp_sv[i]); end
            step();
        end
        ifa.ex_hold_i = 0; ifa.redirect_i = 0;
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL hold_drop_ctl: got %b want 000", ctl); end
        n_chk++; if ({ifa.fwd_a_o, ifa.fwd_b_o} !== {2'd1, 2'd0}) begin n_fail++;
            $display("FAIL hold_drop_fwd: got a=%0d b=%0d want a=1 b=0", ifa.fwd_a_o, ifa.fwd_b_o); end
        drain();
    endtask

    task automatic test_redirect();
        logic [2:0] ctl;
        drive_a(1, 1, 0, 1, 0, 3, 1, 1); step();         // lw r3
        drive_a(1, 3, 5, 1, 1, 4, 1, 0);                 // add r4,r3,r5
        ifa.redirect_i = 1;
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b011) begin n_fail++; $display("FAIL redir_ctl: got %b want 011", ctl); end
        step();
        ifa.redirect_i = 0;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_chk++; if (ifa.stage_valid_o !== 3'b010) begin n_fail++; $display("FAIL redir_sv: got %b want 010", ifa.stage_valid_o); end
        drain();
    endtask

    task automatic test_r0_and_unused();
        drive_a(1, 1, 0, 1, 0, 0, 1, 1); step();         // lw r0
        drive_a(1, 0, 0, 1, 1, 4, 1, 0);                 // add r4,r0,r0
        settle();
        n_chk++; if ({ifa.stall_o, ifa.bubble_o, ifa.fwd_a_o, ifa.fwd_b_o} !== 6'd0) begin n_fail++;
            $display("FAIL r0: got stall=%b a=%0d b=%0d want all 0", ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o); end
        drain();
        drive_a(1, 1, 2, 1, 1, 3, 1, 1); step();         // lw r3
        drive_a(1, 3, 3, 0, 0, 4, 1, 0);                 // reads neither operand
        settle();
        n_chk++; if ({ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o} !== 5'd0) begin n_fail++;
            $display("FAIL unused_ops: got stall=%b a=%0d b=%0d want all 0", ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o); end
        drive_a(0, 3, 3, 1, 1, 4, 1, 0);                 // invalid ID
        settle();
        n_chk++; if ({ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o} !== 5'd0) begin n_fail++;
            $display("FAIL invalid_id: got stall=%b a=%0d b=%0d want all 0", ifa.stall_o, ifa.fwd_a_o, ifa.fwd_b_o); end
        drain();
    endtask

    task automatic test_depth5();
        logic [2:0] ctl;
        drive_b(1, 1, 0, 1, 0, 3, 1, 1); step();         // lw r3
        drive_b(1, 3, 5, 1, 1, 4, 1, 0);
        for (int i = 0; i < 2; i++) begin
            settle();
            ctl = {ifb.stall_o, ifb.bubble_o, ifb.flush_id_o};
            n_chk++; if (ctl !== 3'b110) begin n_fail++; $display("FAIL d5_stall[%0d]: got %b want 110", i, ctl); end
            step();
        end
        settle();
        ctl = {ifb.stall_o, ifb.bubble_o, ifb.flush_id_o};
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL d5_release: got %b want 000", ctl); end
        n_chk++; if ({ifb.fwd_a_o, ifb.stage_valid_o} !== {3'd3, 5'b00100}) begin n_fail++;
            $display("FAIL d5_fwd_sv: got a=%0d sv=%b want a=3 sv=00100", ifb.fwd_a_o, ifb.stage_valid_o); end
        drain();
    endtask

    task automatic test_async_reset();
        logic [2:0] ctl;
        drive_a(1, 1, 0, 1, 0, 3, 1, 1); step();         // lw r3
        drive_a(1, 3, 5, 1, 1, 4, 1, 0);
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if (ctl !== 3'b110) begin n_fail++; $display("FAIL ar_pre: got %b want 110", ctl); end
        #1 reset = 1;
        #1;
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if ({ctl, ifa.fwd_a_o, ifa.fwd_b_o, ifa.stage_valid_o} !== 10'd0) begin n_fail++;
            $display("FAIL ar_mid: got ctl=%b a=%0d b=%0d sv=%b want all 0", ctl, ifa.fwd_a_o, ifa.fwd_b_o, ifa.stage_valid_o); end
        #1 reset = 0;
        settle();
        ctl = {ifa.stall_o, ifa.bubble_o, ifa.flush_id_o};
        n_chk++; if ({ctl, ifa.fwd_a_o, ifa.stage_valid_o} !== 8'd0) begin n_fail++;
            $display("FAIL ar_post: got ctl=%b a=%0d sv=%b want all 0", ctl, ifa.fwd_a_o, ifa.stage_valid_o); end
        drain();
    endtask

    initial begin
        clk    = 0;
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_forward();
        test_wb_bypass();
        test_ex_hold();
        test_redirect();
        test_r0_and_unused();
        test_depth5();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
